// File: rtl/seq_square_16bit.sv
// ---------------------------------------------------------------------------
// seq_square_16bit
//   Sequential shift-add squarer. It takes an N-bit root X and returns the
//   2N-bit square O = X*X after N accumulate cycles. The datapath uses a
//   single 2N-bit ripple adder built from an array of full-adder cells.
//   A start/done handshake admits one operation at a time.
//
//   Ports
//     clk    in   1    rising-edge clock
//     rst    in   1    synchronous reset, active-high, overrides everything
//     start  in   1    request; only looked at in IDLE
//     X      in   N    root operand, captured when start is accepted
//     busy   out  1    high during the N accumulate cycles
//     done   out  1    one-cycle pulse; O is valid from this cycle
//     O      out  2N   square, held until the next accepted start
// ---------------------------------------------------------------------------

// One bit cell of the ripple adder.
module seq_square_16bit_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module seq_square_16bit #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   X,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] O
);
  localparam int W  = 2 * N;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    acc;
  logic [W-1:0]    mcand;
  logic [N-1:0]    mplr;
  logic [CW-1:0]   cnt;

  // Adder operands: acc plus either the shifted multiplicand or zero.
  logic [W-1:0]    add_b;
  logic [W-1:0]    sum;
  logic [W-1:0]    carry;

  assign add_b    = mplr[0] ? mcand : '0;
  assign carry[0] = 1'b0;

  // Ripple chain. The top cell produces no carry-out: for any legal operand
  // the square fits in 2N bits, so that carry is always zero.
  for (genvar i = 0; i < W; i++) begin : g_fa
    if (i < W - 1) begin : g_mid
      seq_square_16bit_fa u_fa (
        .a  (acc[i]),
        .b  (add_b[i]),
        .ci (carry[i]),
        .s  (sum[i]),
        .co (carry[i+1])
      );
    end else begin : g_top
      assign sum[i] = acc[i] ^ add_b[i] ^ carry[i];
    end
  end

  // State register and datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      mcand <= '0;
      mplr  <= '0;
      cnt   <= '0;
      O     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= {{N{1'b0}}, X};
            mplr  <= X;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        CALC: begin
          acc   <= sum;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt + 1'b1;
          // Load the result on the final accumulate edge so O already
          // carries the square during the DONE cycle, alongside done.
          if (cnt == CNT_LAST) O <= sum;
        end
        default: ;
      endcase
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = CALC;
      CALC: begin
        busy = 1'b1;
        if (cnt == CNT_LAST) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule
